uart_msg_assembler: RTL and testbench
=====================================

// Module: uart_msg_assembler
// PURPOSE
//  Downstream of the UART receiver. Consumes the rx_data/rx_done byte strobe
//  and collects bytes into an internal buffer until a terminator character arrives.
//  It then replays the complete message as a valid/ready byte stream with a last flag.
//  This gives consumers whole messages instead of loose bytes.
// PARAMETERS
//  MAX_LEN    32     buffer depth in bytes (max payload, terminator excluded); >=2
//  TERM_CHAR  8'h0A  message terminator (LF); never stored or delivered
//  LEN_W      derived localparam = $clog2(MAX_LEN+1)
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      async active-low reset
//  rx_data    in   8      byte from UART receiver, valid when rx_done=1
//  rx_done    in   1      1-cycle strobe: rx_data valid
//  msg_data   out  8      current message byte
//  msg_valid  out  1      msg_data valid; held until accepted
//  msg_ready  in   1      consumer accepts when msg_valid&msg_ready
//  msg_last   out  1      qualifies final byte of message
//  msg_len    out  LEN_W  byte count of message being delivered; held during DELIVER
//  busy       out  1      1 in DELIVER state
//  overflow   out  1      1-cycle pulse: byte arrived with buffer full
//  rx_drop    out  1      1-cycle pulse: byte discarded because in DELIVER
// BEHAVIOUR
//  Reset: state=COLLECT, wr_ptr=rd_ptr=0; all outputs 0 (msg_data=8'h00).
//  Reset is async, any state. A partial or in-flight message is lost, no further beats.
//  States: COLLECT, DELIVER, DISCARD. Only rx_done-qualified bytes are examined.
//  COLLECT, rx_done:
//   - byte==TERM_CHAR, wr_ptr==0: ignore (empty line), stay COLLECT.
//   - byte==TERM_CHAR, wr_ptr>0: msg_len<=wr_ptr, rd_ptr<=0, ->DELIVER.
//     msg_valid rises the next cycle (1-cycle latency).
//   - other byte, wr_ptr<MAX_LEN: buf[wr_ptr]<=byte, wr_ptr++.
//   - other byte, wr_ptr==MAX_LEN: overflow pulse, wr_ptr<=0, ->DISCARD.
//  DISCARD: bytes dropped silently until TERM_CHAR, then ->COLLECT, wr_ptr=0.
//    A message truncated by overflow is never delivered.
//  DELIVER:
//   - msg_valid=1, msg_data=buf[rd_ptr], msg_last=(rd_ptr==msg_len-1).
//   - data/last stable while valid&!ready.
//   - On accept of a non-last byte: rd_ptr++, next byte valid the following cycle.
//     No bubble; back-to-back beats when ready held high.
//   - On accept of last: msg_valid<=0, wr_ptr<=0, ->COLLECT.
//     An rx_done arriving in that same cycle is dropped (rx_drop pulse).
//   - Any rx_done in DELIVER: byte discarded, rx_drop pulses once per byte.
//   - Exactly MAX_LEN bytes then TERM is legal and delivers MAX_LEN beats.
//  Pointers never wrap; wr_ptr saturates logic at MAX_LEN as above.
//  overflow and rx_drop are never asserted together.
// CONFIGURATION
//  MSG_CR_STRIP_EN defined: byte 8'h0D is discarded in COLLECT and DISCARD.
//    It is not stored, not counted, and never triggers overflow.
//    This makes CR LF lines deliver without the CR.
//  Not defined: 8'h0D is treated as an ordinary data byte.
// TESTING
//  1 "HI\n" (0x48,0x49,0x0A), ready=1
//    -> beats 0x48,0x49; msg_last only on 0x49; msg_len=2; busy for 2 cycles.
//  2 "ABC\n", ready toggled 1-0-1-0-1
//    -> data/last held during stalls; exactly 3 accepts: 0x41,0x42,0x43.
//  3 MAX_LEN=32: 33x 0x55 then "\n"
//    -> overflow pulses once on 33rd byte; no msg_valid; then "Z\n" delivers 1 beat 0x5A.
//  4 32x 0x55 then "\n" -> 32 beats, last on 32nd, msg_len=32, no overflow.
//  5 "\n" alone -> no msg_valid.
//    "Q\n" then byte 0x31 during DELIVER with ready=0 -> rx_drop 1 pulse; only 0x51 delivered.
//  6 rst_n low mid-DELIVER -> all outputs 0 immediately; next "OK\n" delivers 0x4F,0x4B.
//    With MSG_CR_STRIP_EN, "OK\r\n" -> 2 beats.
//    Without it -> 3 beats, last=0x0D.

Source files
------------

// File: rtl/uart_msg_assembler.sv
// Collects UART bytes up to a terminator and replays each complete line as a
// valid/ready byte stream with a last flag. Optional build macro: MSG_CR_STRIP_EN.
module uart_msg_assembler #(
    parameter int         MAX_LEN   = 32,
    parameter logic [7:0] TERM_CHAR = 8'h0A,
    localparam int        LEN_W     = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_done,
    output logic [7:0]       msg_data,
    output logic             msg_valid,
    input  logic             msg_ready,
    output logic             msg_last,
    output logic [LEN_W-1:0] msg_len,
    output logic             busy,
    output logic             overflow,
    output logic             rx_drop
);

    localparam int               IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DELIVER = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0] msg_len_q, msg_len_d;
    logic             msg_valid_q, msg_valid_d;
    logic [7:0]       msg_data_q, msg_data_d;
    logic             msg_last_q, msg_last_d;
    logic             overflow_q, overflow_d;
    logic             rx_drop_q, rx_drop_d;

    logic [7:0]       msg_buf [MAX_LEN];
    logic             buf_we;
    logic [LEN_W-1:0] rd_next;
    logic             is_term;
    logic             is_cr;

    assign is_term = (rx_data == TERM_CHAR);

`ifdef MSG_CR_STRIP_EN
    assign is_cr = (rx_data == 8'h0D);
`else
    assign is_cr = 1'b0;
`endif

    // Next-state logic: all registered outputs are decided here so that the
    // first beat of a message is already loaded when msg_valid rises.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        msg_len_d   = msg_len_q;
        msg_valid_d = msg_valid_q;
        msg_data_d  = msg_data_q;
        msg_last_d  = msg_last_q;
        overflow_d  = 1'b0;
        rx_drop_d   = 1'b0;
        buf_we      = 1'b0;
        rd_next     = rd_ptr_q + ONE;

        unique case (state_q)
            COLLECT: begin
                if (rx_done && !is_cr) begin
                    if (is_term) begin
                        if (wr_ptr_q != '0) begin
                            state_d     = DELIVER;
                            msg_len_d   = wr_ptr_q;
                            rd_ptr_d    = '0;
                            msg_valid_d = 1'b1;
                            msg_data_d  = msg_buf[{IDX_W{1'b0}}];
                            msg_last_d  = (wr_ptr_q == ONE);
                        end
                    end else if (wr_ptr_q < MAX_CNT) begin
                        buf_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE;
                    end else begin
                        overflow_d = 1'b1;
                        wr_ptr_d   = '0;
                        state_d    = DISCARD;
                    end
                end
            end

            // A truncated line is thrown away up to and including its terminator.
            DISCARD: begin
                if (rx_done && is_term) begin
                    state_d  = COLLECT;
                    wr_ptr_d = '0;
                end
            end

            DELIVER: begin
                rx_drop_d = rx_done;
                if (msg_valid_q && msg_ready) begin
                    if (msg_last_q) begin
                        state_d     = COLLECT;
                        msg_valid_d = 1'b0;
                        msg_data_d  = 8'h00;
                        msg_last_d  = 1'b0;
                        wr_ptr_d    = '0;
                        rd_ptr_d    = '0;
                    end else begin
                        rd_ptr_d   = rd_next;
                        msg_data_d = msg_buf[rd_next[IDX_W-1:0]];
                        msg_last_d = (rd_next == (msg_len_q - ONE));
                    end
                end
            end

            default: begin
                state_d     = COLLECT;
                wr_ptr_d    = '0;
                rd_ptr_d    = '0;
                msg_valid_d = 1'b0;
                msg_data_d  = 8'h00;
                msg_last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            msg_len_q   <= '0;
            msg_valid_q <= 1'b0;
            msg_data_q  <= 8'h00;
            msg_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
            rx_drop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            msg_len_q   <= msg_len_d;
            msg_valid_q <= msg_valid_d;
            msg_data_q  <= msg_data_d;
            msg_last_q  <= msg_last_d;
            overflow_q  <= overflow_d;
            rx_drop_q   <= rx_drop_d;
        end
    end

    // Payload storage needs no reset; only entries below wr_ptr are ever read.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            msg_buf[wr_ptr_q[IDX_W-1:0]] <= rx_data;
        end
    end

    assign msg_data  = msg_data_q;
    assign msg_valid = msg_valid_q;
    assign msg_last  = msg_last_q;
    assign msg_len   = msg_len_q;
    assign busy      = (state_q == DELIVER);
    assign overflow  = overflow_q;
    assign rx_drop   = rx_drop_q;

endmodule

// File: tb/tb_uart_msg_assembler.sv
// Scoreboard bench for uart_msg_assembler: a line-level reference model queues
// expected beats; a negedge monitor compares every presented beat against it.
module tb_uart_msg_assembler;

    localparam int         MAX_LEN = 32;
    localparam int         LEN_W   = $clog2(MAX_LEN + 1);
    localparam logic [7:0] TERM    = 8'h0A;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       rx_data;
    logic             rx_done;
    logic [7:0]       msg_data;
    logic             msg_valid;
    logic             msg_ready;
    logic             msg_last;
    logic [LEN_W-1:0] msg_len;
    logic             busy;
    logic             overflow;
    logic             rx_drop;

    uart_msg_assembler #(
        .MAX_LEN  (MAX_LEN),
        .TERM_CHAR(TERM)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .msg_data (msg_data),
        .msg_valid(msg_valid),
        .msg_ready(msg_ready),
        .msg_last (msg_last),
        .msg_len  (msg_len),
        .busy     (busy),
        .overflow (overflow),
        .rx_drop  (rx_drop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]       d;
        logic             last;
        logic [LEN_W-1:0] len;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] m_cur[$];
    bit         m_discard;
    int         exp_overflow, exp_drop;
    int         obs_overflow, obs_drop, beats;
    int         total, bad;
    bit         ready_random;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a line is the bytes seen before a terminator; lines
    // longer than MAX_LEN are lost, empty lines produce nothing.
    task automatic modelByte(input logic [7:0] b);
        if (m_discard) begin
            if (b == TERM) begin
                m_discard = 1'b0;
                m_cur.delete();
            end
`ifdef MSG_CR_STRIP_EN
        end else if (b == 8'h0D) begin
`endif
        end else if (b == TERM) begin
            for (int i = 0; i < m_cur.size(); i++) begin
                exp_q.push_back('{d: m_cur[i], last: (i == m_cur.size() - 1),
                                  len: LEN_W'(m_cur.size())});
            end
            m_cur.delete();
        end else if (m_cur.size() < MAX_LEN) begin
            m_cur.push_back(b);
        end else begin
            exp_overflow++;
            m_discard = 1'b1;
            m_cur.delete();
        end
    endtask

    task automatic driveByte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        modelByte(b);
        driveByte(b);
    endtask

    task automatic sendLine(input string s);
        for (int i = 0; i < s.len(); i++) applyStimulus(s[i]);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 400) checkOutput("idle_timeout", n, 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (ready_random) msg_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: every presented beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (overflow) obs_overflow++;
            if (rx_drop) obs_drop++;
            if (overflow && rx_drop) checkOutput("overflow_and_drop", 1, 0);
            if (msg_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_valid", {24'd0, msg_data}, -1);
                end else begin
                    checkOutput("msg_data", msg_data, exp_q[0].d);
                    checkOutput("msg_last", msg_last, exp_q[0].last);
                    checkOutput("msg_len", msg_len, exp_q[0].len);
                    checkOutput("busy_in_deliver", busy, 1);
                    if (msg_ready) begin
                        void'(exp_q.pop_front());
                        beats++;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int acc0, cnt, ov0, d0, len;
        int pat[5];
        logic [7:0] b;

        rx_data = 8'h00;
        rx_done = 1'b0;
        msg_ready = 1'b0;
        ready_random = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs",
                    {msg_valid, msg_data, msg_last, msg_len, busy, overflow, rx_drop}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] HI line, ready held high");
        msg_ready = 1'b1;
        sendLine("HI\n");
        checkOutput("valid_latency", msg_valid, 1);
        cnt = 0;
        while (busy && cnt < 10) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        checkOutput("busy_cycles", cnt, 2);

        $display("[TB] ABC line, ready toggling");
        msg_ready = 1'b0;
        sendLine("ABC\n");
        pat = '{1, 0, 1, 0, 1};
        acc0 = beats;
        for (int k = 0; k < 5; k++) begin
            msg_ready = pat[k][0];
            @(posedge clk);
            #1;
        end
        msg_ready = 1'b0;
        checkOutput("stall_accepts", beats - acc0, 3);
        checkOutput("abc_busy_after", busy, 0);

        $display("[TB] overflow line then Z");
        ready_random = 1'b1;
        ov0 = obs_overflow;
        for (int i = 0; i < MAX_LEN + 1; i++) applyStimulus(8'h55);
        @(posedge clk);
        #1;
        checkOutput("overflow_pulses", obs_overflow - ov0, 1);
        applyStimulus(TERM);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("no_valid_after_overflow", msg_valid, 0);
        sendLine("Z\n");
        waitIdle();

        $display("[TB] exactly MAX_LEN bytes");
        ov0 = obs_overflow;
        for (int i = 0; i < MAX_LEN; i++) applyStimulus(8'h55);
        applyStimulus(TERM);
        acc0 = beats;
        waitIdle();
        checkOutput("full_line_beats", beats - acc0, MAX_LEN);
        checkOutput("full_line_no_overflow", obs_overflow - ov0, 0);

        $display("[TB] empty line and drops");
        applyStimulus(TERM);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("empty_line_valid", msg_valid, 0);
        ready_random = 1'b0;
        msg_ready = 1'b0;
        sendLine("Q\n");
        d0 = obs_drop;
        exp_drop++;
        driveByte(8'h31);
        @(negedge clk);
        #1;
        checkOutput("rx_drop_pulses", obs_drop - d0, 1);
        ready_random = 1'b1;
        waitIdle();

        ready_random = 1'b0;
        msg_ready = 1'b0;
        sendLine("R\n");
        d0 = obs_drop;
        exp_drop++;
        msg_ready = 1'b1;
        driveByte(8'h33);
        msg_ready = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("drop_on_last_accept", obs_drop - d0, 1);
        checkOutput("busy_after_last", busy, 0);

        $display("[TB] reset during delivery");
        sendLine("XY\n");
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs",
                    {msg_valid, msg_data, msg_last, msg_len, busy, overflow, rx_drop}, 0);
        exp_q.delete();
        m_cur.delete();
        m_discard = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        ready_random = 1'b1;
        sendLine("OK\n");
        waitIdle();
        acc0 = beats;
        sendLine("OK\r\n");
        waitIdle();
`ifdef MSG_CR_STRIP_EN
        checkOutput("ok_cr_beats", beats - acc0, 2);
`else
        checkOutput("ok_cr_beats", beats - acc0, 3);
`endif

        $display("[TB] random lines");
        for (int l = 0; l < 30; l++) begin
            len = $urandom_range(0, MAX_LEN + 2);
            for (int i = 0; i < len; i++) begin
                do b = 8'($urandom); while (b == TERM);
                applyStimulus(b);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            applyStimulus(TERM);
            waitIdle();
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("overflow_total", obs_overflow, exp_overflow);
        checkOutput("drop_total", obs_drop, exp_drop);
        checkOutput("pending_beats", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
